// File: rtl/neuraedge_accum_drain_sched_pkg.sv
// Shared NoC flit layout and drain-scheduler types.
// Flit: [63:62] type, HEAD carries dest/src/row/len; BODY/TAIL carry a zero-extended accumulator word.
package neuraedge_noc_pkg;

    localparam int FLIT_W      = 64;
    localparam int FT_LSB      = 62;
    localparam int HD_DEST_LSB = 54;
    localparam int HD_SRC_LSB  = 46;
    localparam int HD_ROW_LSB  = 40;
    localparam int HD_ROW_W    = 6;
    localparam int HD_LEN_LSB  = 32;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } drain_state_e;

    typedef struct packed {
        flit_type_e           ftype;
        logic [7:0]           dest;
        logic [7:0]           src;
        logic [HD_ROW_W-1:0]  row;
        logic [7:0]           len;
        logic [31:0]          rsvd;
    } head_flit_t;

    typedef struct packed {
        flit_type_e               ftype;
        logic [FLIT_W-3-DATA_W:0] rsvd;
        logic [DATA_W-1:0]        data;
    } data_flit_t;

endpackage

// File: rtl/neuraedge_accum_drain_sched_if.sv
// Accumulator request bus (rows -> scheduler) and flit bus (scheduler -> router local port).
// master = scheduler side, slave = environment side.
interface neuraedge_accum_drain_sched_if #(
    parameter int N_REQ      = 32,
    parameter int ACC_W      = 32,
    parameter int NOC_FLIT_W = 64
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][ACC_W-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic [NOC_FLIT_W-1:0]       flit_out;
    logic                        flit_valid;
    logic                        flit_ready;

    modport master (
        input  req_valid, req_data, flit_ready,
        output req_ready, flit_out, flit_valid
    );

    modport slave (
        output req_valid, req_data, flit_ready,
        input  req_ready, flit_out, flit_valid
    );
endinterface

// File: rtl/neuraedge_accum_drain_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module neuraedge_rr_arbiter #(
    parameter int N_REQ = 32,
    localparam int RID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [RID_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [RID_W-1:0] idx,
    output logic             any
);
    int c;

    always_comb begin
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= N_REQ) c = c - N_REQ;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = c[RID_W-1:0];
            end
        end
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/neuraedge_accum_drain_sched.sv
// Drains PE-row accumulator words into the local NoC port as HEAD + len BODY/TAIL packets.
// Optional NEURAEDGE_DRAIN_TIMEOUT_EN: a stalled burst is zero-filled after TIMEOUT_CYC idle cycles.
module neuraedge_accum_drain_sched
    import neuraedge_noc_pkg::*;
#(
    parameter int N_REQ      = 32,
    parameter int ACC_W      = 32,
`ifdef NEURAEDGE_DRAIN_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1024,
`endif
    parameter int NOC_FLIT_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_enable,
    input  logic [7:0]                  cfg_dest_id,
    input  logic [7:0]                  cfg_src_id,
    input  logic [7:0]                  cfg_burst_len,
    neuraedge_accum_drain_sched_if.master bus,
    output logic                        busy,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        timeout_err
);
    localparam int RID_W = $clog2(N_REQ);

    drain_state_e          state, state_nxt;
    logic [RID_W-1:0]      rr_ptr, g, ptr_nxt, arb_idx;
    logic [N_REQ-1:0]      g_oh, arb_gnt, req_rdy;
    logic [7:0]            len, count, dest_q, src_q;
    logic [NOC_FLIT_W-1:0] flit_q;
    logic                  flit_v, loadable, word_avail, arb_any;
    logic                  grab, load_head, take_word, last_word, flush;
    logic [ACC_W-1:0]      word_d;
    head_flit_t            head_flit;
    data_flit_t            data_flit;

    neuraedge_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign loadable   = !flit_v || bus.flit_ready;
    assign word_avail = bus.req_valid[g];
    assign word_d     = flush ? '0 : bus.req_data[g];
    assign ptr_nxt    = (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;

    assign head_flit = '{ftype: FLIT_HEAD, dest: dest_q, src: src_q,
                         row: HD_ROW_W'(g), len: len, rsvd: '0};
    assign data_flit = '{ftype: last_word ? FLIT_TAIL : FLIT_BODY, rsvd: '0,
                         data: DATA_W'(word_d)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grab      = 1'b0;
        load_head = 1'b0;
        take_word = 1'b0;
        last_word = 1'b0;
        req_rdy   = '0;
        case (state)
            ST_IDLE: if (cfg_enable && arb_any) begin
                grab      = 1'b1;
                state_nxt = ST_HEAD;
            end
            ST_HEAD: if (loadable) begin
                load_head = 1'b1;
                state_nxt = ST_BODY;
            end
            ST_BODY: begin
                // While flushing, words are synthesized as zero and the row is not popped.
                take_word = loadable && (word_avail || flush);
                req_rdy   = (take_word && !flush) ? g_oh : '0;
                last_word = take_word && (count == len - 8'd1);
                if (last_word) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            g      <= '0;
            g_oh   <= '0;
            len    <= '0;
            count  <= '0;
            dest_q <= '0;
            src_q  <= '0;
            flit_q <= '0;
            flit_v <= 1'b0;
        end else begin
            // Packet config is frozen at grant so mid-packet cfg changes wait for the next one.
            if (grab) begin
                g      <= arb_idx;
                g_oh   <= arb_gnt;
                len    <= (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
                dest_q <= cfg_dest_id;
                src_q  <= cfg_src_id;
            end
            if (load_head) begin
                flit_q <= NOC_FLIT_W'(head_flit);
                flit_v <= 1'b1;
                count  <= '0;
            end else if (take_word) begin
                flit_q <= NOC_FLIT_W'(data_flit);
                flit_v <= 1'b1;
                count  <= count + 8'd1;
                if (last_word) rr_ptr <= ptr_nxt;
            end else if (bus.flit_ready) begin
                flit_v <= 1'b0;
            end
        end
    end

`ifdef NEURAEDGE_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tcnt;
    logic          flush_q, terr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt    <= '0;
            flush_q <= 1'b0;
            terr_q  <= 1'b0;
        end else if (state != ST_BODY) begin
            tcnt    <= '0;
            flush_q <= 1'b0;
        end else if (!flush_q) begin
            if (word_avail) begin
                tcnt <= '0;
            end else if (tcnt == T_LIM) begin
                flush_q <= 1'b1;
                terr_q  <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign flush       = flush_q;
    assign timeout_err = terr_q;
`else
    assign flush       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign bus.req_ready  = req_rdy;
    assign bus.flit_out   = flit_q;
    assign bus.flit_valid = flit_v;
    assign busy           = (state != ST_IDLE) || flit_v;
    assign grant_id       = (state == ST_IDLE) ? '0 : g;

endmodule

// File: tb/tb_neuraedge_accum_drain_sched.sv
// Directed bench: row sources feed words, a flit scoreboard checks every accepted flit in order.
module tb_neuraedge_accum_drain_sched;
    localparam int N = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_enable;
    logic [7:0] cfg_dest_id, cfg_src_id, cfg_burst_len;
    logic       busy, timeout_err;
    logic [4:0] grant_id;

    always #5 clk = ~clk;

    neuraedge_accum_drain_sched_if #(.N_REQ(N), .ACC_W(32), .NOC_FLIT_W(64)) bus ();

    neuraedge_accum_drain_sched #(
        .N_REQ(N),
        .ACC_W(32),
`ifdef NEURAEDGE_DRAIN_TIMEOUT_EN
        .TIMEOUT_CYC(16),
`endif
        .NOC_FLIT_W(64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_dest_id   (cfg_dest_id),
        .cfg_src_id    (cfg_src_id),
        .cfg_burst_len (cfg_burst_len),
        .bus           (bus),
        .busy          (busy),
        .grant_id      (grant_id),
        .timeout_err   (timeout_err)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    logic [63:0] sb[$];
    int          src_rem[N];
    int          src_seq[N];
    int          rdy_cnt[N];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_flit  = '0;

    function automatic logic [31:0] word(int r, int s);
        return 32'hA000_0000 | (32'(r) << 16) | 32'(s);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_head(logic [7:0] d, logic [7:0] s, int row, int len);
        sb.push_back({2'b01, d, s, 6'(row), 8'(len), 32'h0});
    endtask

    task automatic exp_word(logic [31:0] data, bit tail);
        sb.push_back({(tail ? 2'b10 : 2'b00), 30'h0, data});
    endtask

    task automatic exp_pkt(logic [7:0] d, logic [7:0] s, int row, int len, int seq0);
        exp_head(d, s, row, len);
        for (int k = 0; k < len; k++) exp_word(word(row, seq0 + k), k == len - 1);
    endtask

    task automatic apply_src();
        for (int r = 0; r < N; r++) begin
            bus.req_valid[r] = (src_rem[r] > 0);
            bus.req_data[r]  = word(r, src_seq[r]);
        end
    endtask

    // One clock: observe just after inputs settle, then advance row sources past the edge.
    task automatic step();
        logic [N-1:0] take;
        #1;
        take = bus.req_ready;
        for (int r = 0; r < N; r++) if (take[r]) rdy_cnt[r]++;
        if (take != '0) chk("rdy_onehot_grant", 64'(take), 64'(N'(1) << grant_id));
        if (prev_stall) begin
            chk("hold_flit_out", bus.flit_out, prev_flit);
            chk("hold_flit_valid", 64'(bus.flit_valid), 64'd1);
        end
        if (bus.flit_valid && !bus.flit_ready) chk("stall_no_rdy", 64'(take), 64'd0);
        if (bus.flit_valid && bus.flit_ready) begin
            if (sb.size() == 0) chk("unexpected_flit", 64'(sb.size()), 64'd1);
            else chk("flit", bus.flit_out, sb.pop_front());
            n_pop++;
        end
        prev_stall = bus.flit_valid && !bus.flit_ready;
        prev_flit  = bus.flit_out;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int r = 0; r < N; r++) if (take[r]) begin
                src_seq[r]++;
                src_rem[r]--;
            end
        end
        apply_src();
        @(negedge clk);
    endtask

    task automatic run_drain(int budget, string tag);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic clear_src();
        for (int r = 0; r < N; r++) begin
            src_rem[r] = 0;
            src_seq[r] = 0;
            rdy_cnt[r] = 0;
        end
        apply_src();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base, k, others;
        rst = 1'b1;
        cfg_enable = 1'b1;
        cfg_dest_id = 8'h12;
        cfg_src_id = 8'h34;
        cfg_burst_len = 8'd4;
        bus.flit_ready = 1'b1;
        clear_src();
        src_rem[1] = 1;
        apply_src();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
        chk("rst_flit_out", bus.flit_out, 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        do_reset();

        // Single row 5, len 4, with 2-cycle head latency.
        src_rem[5] = 4;
        exp_pkt(8'h12, 8'h34, 5, 4, 0);
        apply_src();
        step();
        chk("t1_lat1_valid", 64'(bus.flit_valid), 64'd0);
        chk("t1_grant_id", 64'(grant_id), 64'd5);
        chk("t1_busy", 64'(busy), 64'd1);
        step();
        chk("t1_head_valid", 64'(bus.flit_valid), 64'd1);
        run_drain(40, "t1");
        step();
        others = 0;
        for (int r = 0; r < N; r++) if (r != 5) others += rdy_cnt[r];
        chk("t1_rdy_row5", 64'(rdy_cnt[5]), 64'd4);
        chk("t1_rdy_others", 64'(others), 64'd0);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_grant_idle", 64'(grant_id), 64'd0);

        // Round robin 0,3,31,0 with len 1.
        do_reset();
        cfg_burst_len = 8'd1;
        src_rem[0] = 2;
        src_rem[3] = 1;
        src_rem[31] = 1;
        exp_pkt(8'h12, 8'h34, 0, 1, 0);
        exp_pkt(8'h12, 8'h34, 3, 1, 0);
        exp_pkt(8'h12, 8'h34, 31, 1, 0);
        exp_pkt(8'h12, 8'h34, 0, 1, 1);
        apply_src();
        run_drain(60, "t2");

        // Backpressure during BODY.
        cfg_burst_len = 8'd3;
        src_rem[7] = 3;
        exp_pkt(8'h12, 8'h34, 7, 3, 0);
        apply_src();
        repeat (3) step();
        bus.flit_ready = 1'b0;
        repeat (5) step();
        bus.flit_ready = 1'b1;
        run_drain(30, "t3");
        chk("t3_src_consumed", 64'(src_rem[7]), 64'd0);
        chk("t3_rdy_row7", 64'(rdy_cnt[7]), 64'd3);

        // Async reset mid-packet, then a fresh packet.
        do_reset();
        cfg_burst_len = 8'd8;
        src_rem[0] = 8;
        exp_pkt(8'h12, 8'h34, 0, 8, 0);
        apply_src();
        base = n_pop;
        k = 0;
        while (n_pop - base < 2 && k < 20) begin
            step();
            k++;
        end
        chk("t4_reached_body", 64'(n_pop - base), 64'd2);
        rst = 1'b1;
        #1;
        chk("t4_rst_flit_valid", 64'(bus.flit_valid), 64'd0);
        chk("t4_rst_grant_id", 64'(grant_id), 64'd0);
        chk("t4_rst_busy", 64'(busy), 64'd0);
        sb.delete();
        prev_stall = 1'b0;
        clear_src();
        @(negedge clk);
        rst = 1'b0;
        cfg_burst_len = 8'd2;
        src_rem[0] = 2;
        exp_pkt(8'h12, 8'h34, 0, 2, 0);
        apply_src();
        step();
        step();
        chk("t4_fresh_head", 64'(bus.flit_valid), 64'd1);
        run_drain(20, "t4");

        // Disable mid-packet; cfg changes after grant are ignored.
        cfg_burst_len = 8'd4;
        src_rem[9] = 8;
        exp_pkt(8'h12, 8'h34, 9, 4, 0);
        apply_src();
        base = n_pop;
        k = 0;
        while (n_pop == base && k < 20) begin
            step();
            k++;
        end
        cfg_enable = 1'b0;
        cfg_burst_len = 8'd2;
        cfg_dest_id = 8'h77;
        run_drain(30, "t5");
        repeat (10) step();
        chk("t5_idle_busy", 64'(busy), 64'd0);
        chk("t5_idle_valid", 64'(bus.flit_valid), 64'd0);
        cfg_burst_len = 8'd4;
        cfg_enable = 1'b1;
        exp_pkt(8'h77, 8'h34, 9, 4, 4);
        run_drain(30, "t5b");

        // Granted row runs dry after one word.
        cfg_burst_len = 8'd4;
        src_rem[2] = 1;
        exp_head(8'h77, 8'h34, 2, 4);
        exp_word(word(2, 0), 1'b0);
        apply_src();
        run_drain(20, "t6a");
`ifdef NEURAEDGE_DRAIN_TIMEOUT_EN
        exp_word(32'h0, 1'b0);
        exp_word(32'h0, 1'b0);
        exp_word(32'h0, 1'b1);
        run_drain(60, "t6_flush");
        chk("t6_timeout_err", 64'(timeout_err), 64'd1);
        step();
        chk("t6_busy_after", 64'(busy), 64'd0);
`else
        repeat (20) step();
        chk("t6_stall_busy", 64'(busy), 64'd1);
        chk("t6_stall_grant", 64'(grant_id), 64'd2);
        chk("t6_stall_valid", 64'(bus.flit_valid), 64'd0);
        chk("t6_timeout_err", 64'(timeout_err), 64'd0);
        src_rem[2] = 3;
        apply_src();
        exp_word(word(2, 1), 1'b0);
        exp_word(word(2, 2), 1'b0);
        exp_word(word(2, 3), 1'b1);
        run_drain(20, "t6_resume");
`endif

        // Burst length 0 behaves as 1.
        do_reset();
        cfg_burst_len = 8'd0;
        src_rem[1] = 1;
        exp_pkt(8'h77, 8'h34, 1, 1, 0);
        apply_src();
        run_drain(20, "t7");
        step();
        chk("t7_busy_after", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
